apb_status_bank: RTL and testbench

Parametrised APB read-only status bank. It samples `NCH` independent `DWIDTH`-bit status inputs every `PCLK` and adds per-channel change detection with write-1-to-clear sticky flags, an interrupt mask and a combined interrupt output. Address decode with error response is also included. It sits on the peripheral APB alongside the SPI control/status registers and replaces single-register read-only instances.

---
 rtl/apb_status_bank.sv | 108 ++++++++++
 tb/tb_apb_status_bank.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_status_bank.sv
// rtl/apb_status_bank.sv - APB status bank: sampled channels, W1C change flags, irq mask (option: APB_STATUS_SYNC_EN)
module apb_status_bank #(
    parameter int DWIDTH = 8,
    parameter int NCH    = 4,
    parameter int AWIDTH = 8
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [AWIDTH-1:0]       PADDR,
    input  logic [DWIDTH-1:0]       PWDATA,
    output logic [DWIDTH-1:0]       PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    input  logic [NCH*DWIDTH-1:0]   status_in,
    output logic                    irq
);
    localparam int WW = AWIDTH - 2;
    localparam logic [WW-1:0] W_CHG  = WW'(NCH);
    localparam logic [WW-1:0] W_MASK = WW'(NCH + 1);

    logic [WW-1:0]          w;
    logic                   access;
    logic                   err;
    logic                   wr_en;
    logic [NCH*DWIDTH-1:0]  s;
    logic [NCH*DWIDTH-1:0]  val_q;
    logic [NCH-1:0]         chg_q;
    logic [NCH-1:0]         mask_q;
    logic [NCH-1:0]         chg_set;
    logic [NCH-1:0]         chg_clr;
    logic [DWIDTH-1:0]      rdata;
    logic                   unused_bits;

    assign w      = PADDR[AWIDTH-1:2];
    assign access = PSEL & PENABLE;
    assign err    = access & ((w > W_MASK) | (PWRITE & (w < W_CHG)));
    assign wr_en  = access & PWRITE & ~err;

`ifdef APB_STATUS_SYNC_EN
    logic [NCH*DWIDTH-1:0] sync_q1;
    logic [NCH*DWIDTH-1:0] sync_q2;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= status_in;
            sync_q2 <= sync_q1;
        end
    end

    assign s = sync_q2;
`else
    assign s = status_in;
`endif

    // A flag is raised on exactly the edge where val_q picks up a new value.
    always_comb begin
        chg_set = '0;
        for (int i = 0; i < NCH; i++) begin
            chg_set[i] = (s[i*DWIDTH +: DWIDTH] != val_q[i*DWIDTH +: DWIDTH]);
        end
    end

    assign chg_clr = (wr_en && (w == W_CHG)) ? PWDATA[NCH-1:0] : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            val_q  <= '0;
            chg_q  <= '0;
            mask_q <= '0;
        end else begin
            val_q <= s;
            chg_q <= (chg_q & ~chg_clr) | chg_set;
            if (wr_en && (w == W_MASK)) begin
                mask_q <= PWDATA[NCH-1:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (access && !PWRITE && !err) begin
            for (int i = 0; i < NCH; i++) begin
                if (w == WW'(i)) begin
                    rdata = val_q[i*DWIDTH +: DWIDTH];
                end
            end
            if (w == W_CHG) begin
                rdata[NCH-1:0] = chg_q;
            end
            if (w == W_MASK) begin
                rdata[NCH-1:0] = mask_q;
            end
        end
    end

    assign PRDATA      = rdata;
    assign PREADY      = 1'b1;
    assign PSLVERR     = err;
    assign irq         = |(chg_q & mask_q);
    assign unused_bits = ^{PADDR[1:0], PWDATA};

endmodule

// File: tb/tb_apb_status_bank.sv
// tb/tb_apb_status_bank.sv - randomized self-checking bench for apb_status_bank
module tb_apb_status_bank;
    localparam int DWIDTH = 8;
    localparam int NCH    = 4;
    localparam int AWIDTH = 8;
`ifdef APB_STATUS_SYNC_EN
    localparam int L = 3;
`else
    localparam int L = 1;
`endif

    logic        PCLK;
    logic        PRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [7:0]  PWDATA;
    logic [7:0]  PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] status_in;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  m_val [4];
    logic [3:0]  m_chg;
    logic [3:0]  m_mask;
    logic [31:0] hist [$];

    apb_status_bank #(.DWIDTH(DWIDTH), .NCH(NCH), .AWIDTH(AWIDTH)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .status_in (status_in),
        .irq       (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: each channel's register shows the input as it was L edges ago.
    always @(posedge PCLK or negedge PRESETn) begin
        logic [31:0] s;
        logic [3:0]  clr;
        logic [3:0]  set;
        int          w;
        if (!PRESETn) begin
            for (int i = 0; i < 4; i++) m_val[i] <= 8'h00;
            m_chg  <= 4'h0;
            m_mask <= 4'h0;
            hist.delete();
        end else begin
            hist.push_front(status_in);
            if (hist.size() > L) void'(hist.pop_back());
            s   = (hist.size() == L) ? hist[L-1] : 32'h0;
            w   = int'(PADDR[7:2]);
            clr = 4'h0;
            set = 4'h0;
            if (PSEL && PENABLE && PWRITE) begin
                if (w == 4) clr = PWDATA[3:0];
                if (w == 5) m_mask <= PWDATA[3:0];
            end
            for (int ch = 0; ch < 4; ch++) begin
                if (s[ch*8 +: 8] != m_val[ch]) set[ch] = 1'b1;
                m_val[ch] <= s[ch*8 +: 8];
            end
            m_chg <= (m_chg & ~clr) | set;
        end
    end

    function automatic logic exp_err(input logic [7:0] a, input logic wr);
        int w;
        w = int'(a[7:2]);
        return (w > 5) || (wr && (w < 4));
    endfunction

    function automatic logic [7:0] exp_rd(input logic [7:0] a);
        int w;
        w = int'(a[7:2]);
        if (w < 4) return m_val[w];
        if (w == 4) return {4'h0, m_chg};
        if (w == 5) return {4'h0, m_mask};
        return 8'h00;
    endfunction

    task automatic apb_idle();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [7:0] data, input string tag,
                             output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        err = PSLVERR;
        check({tag, "_err"}, PSLVERR, exp_err(addr, 1'b1));
        check({tag, "_rdata"}, PRDATA, 0);
        check({tag, "_pready"}, PREADY, 1);
        @(negedge PCLK);
        apb_idle();
    endtask

    task automatic apb_read(input logic [7:0] addr, input string tag,
                            output logic [7:0] data, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        data = PRDATA;
        err  = PSLVERR;
        check({tag, "_rdata"}, PRDATA, exp_rd(addr));
        check({tag, "_err"}, PSLVERR, exp_err(addr, 1'b0));
        @(negedge PCLK);
        apb_idle();
    endtask

    initial begin
        logic [7:0] d;
        logic       e;
        apb_idle();
        PADDR     = 8'h00;
        PWDATA    = 8'h00;
        PRESETn   = 1'b0;
        status_in = 32'hA5A5_A5A5;

        repeat (2) @(negedge PCLK);
        #1;
        check("rst_prdata", PRDATA, 0);
        check("rst_irq", irq, 0);
        check("rst_pready", PREADY, 1);
        check("rst_pslverr", PSLVERR, 0);
        PSEL = 1'b1; PENABLE = 1'b1; PADDR = 8'h10;
        #1;
        check("rst_chg_read", PRDATA, 0);
        apb_idle();
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (L-1) @(negedge PCLK);
        apb_read(8'h04, "rst_val1", d, e);
        check("rst_val1_const", d, 8'hA5);
        apb_read(8'h10, "rst_chg", d, e);
        check("rst_chg_const", d, 8'h0F);

        apb_write(8'h10, 8'h0F, "clr_all", e);
        apb_write(8'h14, 8'h04, "mask4", e);
        status_in[23:16] = 8'h3C;
        repeat (L-1) @(negedge PCLK);
        #1 check("chg2_irq_early", irq, 0);
        @(negedge PCLK);
        #1 check("chg2_irq", irq, 1);
        apb_read(8'h10, "chg2", d, e);
        check("chg2_const", d, 8'h04);
        apb_write(8'h10, 8'h04, "w1c2", e);
        #1 check("w1c2_irq", irq, 0);
        apb_read(8'h10, "w1c2_chg", d, e);
        check("w1c2_chg_const", d, 8'h00);

        status_in[7:0] = 8'h00;
        repeat (L+1) @(negedge PCLK);
        apb_write(8'h10, 8'h0F, "pre_coll_clr", e);
        if (L == 3) begin
            status_in[7:0] = 8'h01;
            @(negedge PCLK);
        end
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 8'h01;
        @(negedge PCLK);
        PENABLE = 1'b1;
        if (L == 1) status_in[7:0] = 8'h01;
        @(negedge PCLK);
        apb_idle();
        apb_read(8'h10, "coll", d, e);
        check("coll_chg0", d[0], 1);

        apb_write(8'h14, 8'h00, "mask0", e);
        status_in = 32'h1122_3344;
        repeat (L) @(negedge PCLK);
        #1 check("masked_irq", irq, 0);
        apb_read(8'h10, "masked_chg", d, e);
        check("masked_chg_const", d, 8'h0F);
        apb_write(8'h14, 8'h01, "mask1", e);
        #1 check("mask1_irq", irq, 1);

        apb_write(8'h00, 8'h55, "err_wr", e);
        check("err_wr_const", e, 1);
        apb_read(8'h00, "err_wr_val0", d, e);
        check("err_wr_val0_const", d, 8'h44);
        apb_read(8'h18, "err_rd", d, e);
        check("err_rd_data_const", d, 8'h00);
        check("err_rd_err_const", e, 1);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h04;
        #1;
        check("setup_rdata", PRDATA, 0);
        check("setup_err", PSLVERR, 0);
        @(negedge PCLK);
        apb_idle();

        apb_write(8'h14, 8'h08, "lat_mask", e);
        apb_write(8'h10, 8'h0F, "lat_clr", e);
        status_in[31:24] = 8'hFF;
        repeat (L-1) @(negedge PCLK);
        #1 check("lat_irq_early", irq, 0);
        @(negedge PCLK);
        #1 check("lat_irq", irq, 1);
        apb_read(8'h0C, "lat_val3", d, e);
        check("lat_val3_const", d, 8'hFF);

        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h14; PWDATA = 8'h0F;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #2 PRESETn = 1'b0;
        #1 check("mid_rst_irq", irq, 0);
        @(negedge PCLK);
        apb_idle();
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (L+1) @(negedge PCLK);
        apb_read(8'h14, "mid_rst_mask", d, e);
        check("mid_rst_mask_const", d, 8'h00);

        repeat (300) begin
            if ($urandom_range(0, 2) == 0) begin
                int ch;
                ch = $urandom_range(0, 3);
                status_in[ch*8 +: 8] = 8'($urandom);
            end
            PADDR = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 27));
            if ($urandom_range(0, 1) == 1) apb_write(PADDR, 8'($urandom), "rnd_wr", e);
            else apb_read(PADDR, "rnd_rd", d, e);
            #1 check("rnd_irq", irq, |(m_chg & m_mask));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
